bitstream_field_reader: RTL and testbench
=========================================

// Module: bitstream_field_reader
// PURPOSE
//  Parametrised MSB-first bit reader for the OBU parser front end. Packs incoming
//  PARSER_DATA_WIDTH words into a 2-word window. Serves READ/PEEK/SKIP/ALIGN commands
//  of 0..MAX_FIELD_WIDTH bits with valid/ready on every interface. Tracks the absolute
//  bit position, so header parsers get byte_alignment() and field extraction in one block.
// PARAMETERS
//  DATA_WIDTH       32              input word width (= PARSER_DATA_WIDTH)
//  MAX_FIELD_WIDTH  32              largest field per command, <= DATA_WIDTH
//  LEN_WIDTH        $clog2(MAX_FIELD_WIDTH+1)+1  cmd_len width (extra bit exposes oversize)
//  BUF_WIDTH        2*DATA_WIDTH    bit window depth
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 synchronous, active-high reset
//  flush      in   1                 sync clear of window/output/bit_pos (new OBU)
//  in_data    in   DATA_WIDTH        next bitstream word, first bit at MSB
//  in_valid   in   1                 in_data valid
//  in_ready   out  1                 window can take a full word
//  cmd_valid  in   1                 command valid
//  cmd_ready  out  1                 command accepted this cycle when cmd_valid
//  cmd_op     in   2                 field_op_e: READ=0 PEEK=1 SKIP=2 ALIGN=3
//  cmd_len    in   LEN_WIDTH         field length in bits (ignored for ALIGN)
//  out_data   out  MAX_FIELD_WIDTH   field, right-aligned, zero-extended
//  out_valid  out  1                 out_data valid (READ/PEEK only)
//  out_ready  in   1                 consumer takes out_data
//  level      out  $clog2(BUF_WIDTH+1) valid bits currently in window
//  bit_pos    out  32                bits consumed since reset/flush, wraps mod 2^32
//  err        out  1                 sticky: a command had cmd_len > MAX_FIELD_WIDTH
// BEHAVIOUR
//  - Reset/flush (flush = same effect, rst wins): level=0, window=0, out_valid=0,
//    out_data=0, bit_pos=0, err=0. in_ready=0 and cmd_ready=0 while rst is high.
//  - Window: left-justified; bit BUF_WIDTH-1 is the next bit. in_ready=(level<=BUF_WIDTH-DATA_WIDTH),
//    from registered level only. An accepted word lands directly below the surviving bits.
//  - need: READ/PEEK/SKIP need eff_len bits, eff_len = min(cmd_len, MAX_FIELD_WIDTH).
//    ALIGN needs (8 - bit_pos[2:0]) % 8 bits.
//  - cmd_ready = !rst && level>=need && (!out_valid || out_ready || op is SKIP/ALIGN).
//    Computed combinationally from cmd_op/cmd_len and registered state. Never depends on cmd_valid.
//  - consumed: READ/SKIP/ALIGN consume "need" bits; PEEK consumes 0.
//    level_next = level + (in fire ? DATA_WIDTH : 0) - (cmd fire ? consumed : 0).
//    An input fire and a command fire in the same cycle are both legal and both apply.
//  - Latency: READ/PEEK accepted in cycle N give out_valid=1 in N+1. out_data = top eff_len
//    bits of the pre-consume window. out_valid/out_data hold until out_ready. If a new READ/PEEK
//    fires in the same cycle as out_ready, there is no bubble: back-to-back 1 field/cycle.
//  - eff_len=0 READ/PEEK: out_data=0, out_valid pulses, nothing consumed.
//  - ALIGN at a byte boundary: no-op, accepted immediately, no output.
//  - bit_pos += consumed on each cmd fire and wraps silently at 2^32.
//  - err set by any fired command with cmd_len>MAX_FIELD_WIDTH, cleared only by rst/flush.
//  - flush in the same cycle as in/cmd fire: the fires are discarded. in_ready and cmd_ready
//    are forced 0 during flush.
// STRUCTURE
//  - obu_parser_pkg: PARSER_DATA_WIDTH, field_op_e enum (2-bit), FIELD_OP_* constants.
//  - Sub-module bit_window_shifter (combinational): window<<consumed merged with in_data>>fill.
//    Top-level holds the counters, handshake and output register.
// TESTING
//  1. word 0xA5C30F12; READ 4 -> 0x0000000A; READ 8 -> 0x5C; bit_pos=12, level=20.
//  2. continue: ALIGN -> consumes 4 (bit_pos 16), no out_valid; READ 8 -> 0x0F.
//  3. words 0x12345678,0x9ABCDEF0; SKIP 28; READ 8 -> 0x89 (straddle); bit_pos=36.
//  4. PEEK 16 twice -> 0x1234 both, bit_pos=0; then READ 16 -> 0x1234, bit_pos=16.
//  5. out_ready=0 after READ: out_valid/out_data held 5 cycles, cmd_ready=0; level=64 -> in_ready=0.
//  6. level=40,out_valid=1, flush pulse -> next cycle level=0,out_valid=0,bit_pos=0;
//     READ cmd_len=33 -> 32-bit field, err=1 until flush.

Source files
------------

// File: rtl/obu_parser_pkg.sv
// Shared types for the OBU parser front end: word width, field command opcodes
// and the small helpers used by the bit reader.
package obu_parser_pkg;

   localparam int PARSER_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      FIELD_OP_READ  = 2'd0,
      FIELD_OP_PEEK  = 2'd1,
      FIELD_OP_SKIP  = 2'd2,
      FIELD_OP_ALIGN = 2'd3
   } field_op_e;

   // Bits still missing to reach the next byte boundary: (8 - pos % 8) % 8.
   function automatic logic [2:0] align_bits(input logic [2:0] pos_lo);
      return 3'(3'd0 - pos_lo);
   endfunction

   function automatic logic produces_field(input field_op_e op);
      return (op == FIELD_OP_READ) || (op == FIELD_OP_PEEK);
   endfunction

endpackage

// File: rtl/bit_window_shifter.sv
// Next-window builder: drops consumed bits off the top of the left-justified
// window and slots an incoming word in directly below the surviving bits.
module bit_window_shifter #(
   parameter int DATA_WIDTH = 32,
   parameter int BUF_WIDTH  = 64,
   parameter int LVL_WIDTH  = 7
) (
   input  logic [BUF_WIDTH-1:0]  window,
   input  logic [LVL_WIDTH-1:0]  level,
   input  logic [LVL_WIDTH-1:0]  consumed,
   input  logic                  in_en,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [BUF_WIDTH-1:0]  window_next
);

   logic [LVL_WIDTH-1:0] fill;
   logic [BUF_WIDTH-1:0] word_top;

   // Bits below level are always zero, so OR-merging the new word is safe.
   assign fill     = level - consumed;
   assign word_top = {in_data, {(BUF_WIDTH-DATA_WIDTH){1'b0}}};

   always_comb begin
      window_next = window << consumed;
      if (in_en) begin
         window_next = window_next | (word_top >> fill);
      end
   end

endmodule

// File: rtl/bitstream_field_reader.sv
// MSB-first field reader: two-word bit window with READ/PEEK/SKIP/ALIGN commands,
// absolute bit position tracking and a one-deep registered field output.
module bitstream_field_reader
   import obu_parser_pkg::*;
#(
   parameter int DATA_WIDTH      = PARSER_DATA_WIDTH,
   parameter int MAX_FIELD_WIDTH = 32,
   parameter int LEN_WIDTH       = $clog2(MAX_FIELD_WIDTH+1)+1,
   parameter int BUF_WIDTH       = 2*DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [1:0]                     cmd_op,
   input  logic [LEN_WIDTH-1:0]           cmd_len,
   output logic [MAX_FIELD_WIDTH-1:0]     out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(BUF_WIDTH+1)-1:0] level,
   output logic [31:0]                    bit_pos,
   output logic                           err
);

   localparam int LVL_WIDTH = $clog2(BUF_WIDTH+1);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN   = LEN_WIDTH'(MAX_FIELD_WIDTH);
   localparam logic [LVL_WIDTH-1:0] WORD_BITS = LVL_WIDTH'(DATA_WIDTH);
   localparam logic [LVL_WIDTH-1:0] IN_LIMIT  = LVL_WIDTH'(BUF_WIDTH - DATA_WIDTH);

   logic [BUF_WIDTH-1:0] window;
   logic [BUF_WIDTH-1:0] window_next;
   logic [LVL_WIDTH-1:0] level_next;
   logic [LVL_WIDTH-1:0] need;
   logic [LVL_WIDTH-1:0] consumed;
   logic [LEN_WIDTH-1:0] eff_len;
   logic [LEN_WIDTH-1:0] field_shift;
   logic [MAX_FIELD_WIDTH-1:0] field;
   logic                 len_oversize;
   logic                 out_free;
   logic                 in_fire;
   logic                 cmd_fire;
   field_op_e            op;

   assign op           = field_op_e'(cmd_op);
   assign len_oversize = (cmd_len > MAX_LEN);
   assign eff_len      = len_oversize ? MAX_LEN : cmd_len;
   assign out_free     = !out_valid || out_ready;

   always_comb begin
      need = LVL_WIDTH'(eff_len);
      if (op == FIELD_OP_ALIGN) begin
         need = LVL_WIDTH'(align_bits(bit_pos[2:0]));
      end
   end

   // Handshakes only look at registered state and the command fields, never at cmd_valid.
   assign in_ready  = !rst && !flush && (level <= IN_LIMIT);
   assign cmd_ready = !rst && !flush && (level >= need) &&
                      (out_free || !produces_field(op));
   assign in_fire   = in_valid && in_ready;
   assign cmd_fire  = cmd_valid && cmd_ready;

   always_comb begin
      consumed = '0;
      if (cmd_fire && (op != FIELD_OP_PEEK)) begin
         consumed = need;
      end
   end

   assign level_next = level + (in_fire ? WORD_BITS : '0) - consumed;

   // A zero-length field shifts by the full width, which yields zero.
   assign field_shift = MAX_LEN - eff_len;
   assign field       = window[BUF_WIDTH-1 -: MAX_FIELD_WIDTH] >> field_shift;

   bit_window_shifter #(
      .DATA_WIDTH (DATA_WIDTH),
      .BUF_WIDTH  (BUF_WIDTH),
      .LVL_WIDTH  (LVL_WIDTH)
   ) u_shifter (
      .window      (window),
      .level       (level),
      .consumed    (consumed),
      .in_en       (in_fire),
      .in_data     (in_data),
      .window_next (window_next)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         window    <= '0;
         level     <= '0;
         bit_pos   <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         window  <= window_next;
         level   <= level_next;
         bit_pos <= bit_pos + 32'(consumed);
         if (cmd_fire && len_oversize) begin
            err <= 1'b1;
         end
         if (cmd_fire && produces_field(op)) begin
            out_valid <= 1'b1;
            out_data  <= field;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bitstream_field_reader.sv
// Directed bench for bitstream_field_reader: a table of word/command steps with
// hand-computed results, plus hand-written handshake and flush sequences.
module tb_bitstream_field_reader;
   import obu_parser_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [6:0]  cmd_len;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  level;
   logic [31:0] bit_pos;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bitstream_field_reader dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .bit_pos   (bit_pos),
      .err       (err)
   );

   typedef struct {
      int          kind;     // 0 flush, 1 push word, 2 command
      logic [31:0] word;
      logic [1:0]  op;
      logic [6:0]  len;
      logic [31:0] exp_data;
      logic        exp_ov;
      logic [31:0] exp_bp;
      logic [6:0]  exp_lvl;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int kind, logic [31:0] word, logic [1:0] op, logic [6:0] len,
                               logic [31:0] d, logic ov, logic [31:0] bp, logic [6:0] lvl);
      vec_t v;
      v.kind = kind; v.word = word; v.op = op; v.len = len;
      v.exp_data = d; v.exp_ov = ov; v.exp_bp = bp; v.exp_lvl = lvl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      in_data  = w;
      in_valid = 1'b1;
      #1;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL push_timeout: in_ready got 0 expected 1");
      end else begin
         @(negedge clk);
      end
      in_valid = 1'b0;
      #1;
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [6:0] len);
      cmd_op    = op;
      cmd_len   = len;
      cmd_valid = 1'b1;
      #1;
      for (int i = 0; i < 20 && !cmd_ready; i++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL cmd_timeout: cmd_ready got 0 expected 1");
      end else begin
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      in_data = '0; in_valid = 1'b0;
      cmd_valid = 1'b1; cmd_op = FIELD_OP_READ; cmd_len = 7'd0;
      out_ready = 1'b1;

      // Reset state and handshakes held low during reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_level", level, 0);
      chk("rst_bit_pos", bit_pos, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
      cmd_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Table-driven field extraction
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 32'hA5C30F12, 0, 0, 0, 0, 0, 32));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 4, 32'h0A, 1, 4, 28));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 8, 32'h5C, 1, 12, 20));
      vecs.push_back(mk(2, 0, FIELD_OP_ALIGN, 0, 0, 0, 16, 16));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 8, 32'h0F, 1, 24, 8));
      vecs.push_back(mk(2, 0, FIELD_OP_ALIGN, 0, 0, 0, 24, 8));
      vecs.push_back(mk(2, 0, FIELD_OP_PEEK, 8, 32'h12, 1, 24, 8));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 0, 32'h00, 1, 24, 8));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 8, 32'h12, 1, 32, 0));
      vecs.push_back(mk(2, 0, FIELD_OP_ALIGN, 0, 0, 0, 32, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 32'h12345678, 0, 0, 0, 0, 0, 32));
      vecs.push_back(mk(1, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 64));
      vecs.push_back(mk(2, 0, FIELD_OP_SKIP, 28, 0, 0, 28, 36));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 8, 32'h89, 1, 36, 28));
      vecs.push_back(mk(2, 0, FIELD_OP_ALIGN, 0, 0, 0, 40, 24));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 24, 32'hBCDEF0, 1, 64, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 32'h12345678, 0, 0, 0, 0, 0, 32));
      vecs.push_back(mk(2, 0, FIELD_OP_PEEK, 16, 32'h1234, 1, 0, 32));
      vecs.push_back(mk(2, 0, FIELD_OP_PEEK, 16, 32'h1234, 1, 0, 32));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 16, 32'h1234, 1, 16, 16));
      vecs.push_back(mk(2, 0, FIELD_OP_READ, 16, 32'h5678, 1, 32, 0));

      @(negedge clk);
      foreach (vecs[i]) begin
         case (vecs[i].kind)
            0: flush_pulse();
            1: push_word(vecs[i].word);
            default: begin
               do_cmd(vecs[i].op, vecs[i].len);
               chk($sformatf("row%0d_out_valid", i), out_valid, vecs[i].exp_ov);
               if (vecs[i].exp_ov)
                  chk($sformatf("row%0d_out_data", i), out_data, vecs[i].exp_data);
            end
         endcase
         chk($sformatf("row%0d_bit_pos", i), bit_pos, vecs[i].exp_bp);
         chk($sformatf("row%0d_level", i), level, vecs[i].exp_lvl);
      end

      // Output stall, full window, then back-to-back reads
      flush_pulse();
      push_word(32'h12345678);
      push_word(32'h9ABCDEF0);
      chk("full_level", level, 64);
      chk("full_in_ready", in_ready, 0);
      out_ready = 1'b0;
      cmd_op = FIELD_OP_READ; cmd_len = 7'd8; cmd_valid = 1'b1;
      #1;
      chk("stall_first_ready", cmd_ready, 1);
      @(negedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d_out_valid", i), out_valid, 1);
         chk($sformatf("stall%0d_out_data", i), out_data, 32'h12);
         chk($sformatf("stall%0d_cmd_ready", i), cmd_ready, 0);
         @(negedge clk);
         #1;
      end
      chk("stall_level", level, 56);
      chk("stall_in_ready", in_ready, 0);
      out_ready = 1'b1;
      #1;
      chk("b2b_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      #1;
      chk("b2b1_out_data", out_data, 32'h34);
      chk("b2b1_out_valid", out_valid, 1);
      @(negedge clk);
      #1;
      chk("b2b2_out_data", out_data, 32'h56);
      chk("b2b2_bit_pos", bit_pos, 24);
      cmd_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("b2b_end_out_valid", out_valid, 0);
      chk("b2b_end_level", level, 40);

      // Flush while output pending and with fires offered in the same cycle
      out_ready = 1'b0;
      do_cmd(FIELD_OP_PEEK, 8);
      chk("pre_flush_out_valid", out_valid, 1);
      chk("pre_flush_out_data", out_data, 32'h78);
      chk("pre_flush_level", level, 40);
      in_data = 32'hFFFF_FFFF; in_valid = 1'b1;
      cmd_op = FIELD_OP_SKIP; cmd_len = 7'd8; cmd_valid = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_in_ready", in_ready, 0);
      chk("flush_cmd_ready", cmd_ready, 0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("flush_level", level, 0);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_out_data", out_data, 0);
      chk("flush_bit_pos", bit_pos, 0);

      // Oversize length clamps to 32 bits and sets sticky err
      push_word(32'hDEADBEEF);
      do_cmd(FIELD_OP_READ, 7'd33);
      chk("over_out_data", out_data, 32'hDEADBEEF);
      chk("over_err", err, 1);
      chk("over_bit_pos", bit_pos, 32);
      chk("over_level", level, 0);
      push_word(32'h5F000000);
      do_cmd(FIELD_OP_READ, 7'd4);
      chk("after_over_data", out_data, 32'h5);
      repeat (3) @(negedge clk);
      #1;
      chk("err_sticky", err, 1);
      flush_pulse();
      chk("err_cleared", err, 0);

      // Input word and command firing in the same cycle
      push_word(32'h12345678);
      in_data = 32'h9ABCDEF0; in_valid = 1'b1;
      cmd_op = FIELD_OP_READ; cmd_len = 7'd8; cmd_valid = 1'b1;
      #1;
      chk("dual_in_ready", in_ready, 1);
      chk("dual_cmd_ready", cmd_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; cmd_valid = 1'b0;
      #1;
      chk("dual_level", level, 56);
      chk("dual_out_data", out_data, 32'h12);
      do_cmd(FIELD_OP_READ, 7'd32);
      chk("dual_merge_data", out_data, 32'h3456789A);
      chk("dual_merge_level", level, 24);

      // Reset mid-stream
      rst = 1'b1;
      cmd_op = FIELD_OP_READ; cmd_len = 7'd0;
      #1;
      chk("midrst_cmd_ready", cmd_ready, 0);
      chk("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_level", level, 0);
      chk("midrst_bit_pos", bit_pos, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
